// File: rtl/ibuff_pkg.sv
// rtl/ibuff_pkg.sv - shared defaults, entry type and helpers for the instruction buffer queue
`ifndef FETCH_WIDTH
`define FETCH_WIDTH 2
`endif
`ifndef DISPATCH_WIDTH
`define DISPATCH_WIDTH 4
`endif

package ibuff_pkg;

    localparam int IBUFF_WPORT = 2 * `FETCH_WIDTH;
    localparam int IBUFF_RPORT = `DISPATCH_WIDTH;
    localparam int IBUFF_DEPTH = 16;
    localparam int IBUFF_WIDTH = 8;

    typedef logic [IBUFF_WIDTH-1:0] ibuff_entry_t;

    function automatic bit is_pow2(input int v);
        return (v > 0) && ((v & (v - 1)) == 0);
    endfunction

endpackage

// File: rtl/ibuff_storage.sv
// rtl/ibuff_storage.sv - multi-port entry array, WPORT write ports, RPORT combinational read ports, no reset
module ibuff_storage #(
    parameter int DEPTH = 16,
    parameter int WIDTH = 8,
    parameter int WPORT = 4,
    parameter int RPORT = 4,
    parameter int INDEX = $clog2(DEPTH)
) (
    input  logic                     clk,
    input  logic [WPORT-1:0]         we,
    input  logic [WPORT*INDEX-1:0]   waddr,
    input  logic [WPORT*WIDTH-1:0]   wdata,
    input  logic [RPORT*INDEX-1:0]   raddr,
    output logic [RPORT*WIDTH-1:0]   rdata
);

    logic [WIDTH-1:0] mem [DEPTH];

    // write every enabled lane; the queue guarantees lane addresses are distinct
    always_ff @(posedge clk) begin
        for (int k = 0; k < WPORT; k++) begin
            if (we[k]) begin
                mem[waddr[k*INDEX +: INDEX]] <= wdata[k*WIDTH +: WIDTH];
            end
        end
    end

    // read lanes are purely combinational from the registered array
    always_comb begin
        rdata = '0;
        for (int k = 0; k < RPORT; k++) begin
            rdata[k*WIDTH +: WIDTH] = mem[raddr[k*INDEX +: INDEX]];
        end
    end

endmodule

// File: rtl/ibuff_queue.sv
// rtl/ibuff_queue.sv - multi-push multi-pop circular instruction buffer with flush and overflow pulse
module ibuff_queue
    import ibuff_pkg::*;
#(
    parameter int WPORT = IBUFF_WPORT,
    parameter int RPORT = IBUFF_RPORT,
    parameter int DEPTH = IBUFF_DEPTH,
    parameter int WIDTH = IBUFF_WIDTH,
    localparam int INDEX = $clog2(DEPTH),
    localparam int WCW   = $clog2(WPORT + 1),
    localparam int RCW   = $clog2(RPORT + 1)
) (
    input  logic                   clk,
    input  logic                   reset,
    input  logic                   flush_i,
    input  logic [WCW-1:0]         wr_cnt_i,
    input  logic [WPORT*WIDTH-1:0] wr_data_i,
    input  logic [RCW-1:0]         rd_cnt_i,
    output logic [RPORT*WIDTH-1:0] rd_data_o,
    output logic [RPORT-1:0]       rd_valid_o,
    output logic [INDEX:0]         count_o,
    output logic                   stall_o,
    output logic                   overflow_o
);

    localparam int CW = INDEX + 1;

    if (!is_pow2(DEPTH) || DEPTH < WPORT || DEPTH < RPORT) begin : g_bad_depth
        $error("ibuff_queue: DEPTH must be a power of two and at least max(WPORT,RPORT)");
    end

    logic [INDEX-1:0]       head;
    logic [INDEX-1:0]       tail;
    logic [CW-1:0]          count;
    logic                   overflow;

    logic [CW-1:0]          free_cnt;
    logic [CW-1:0]          wr_ext;
    logic [CW-1:0]          rd_ext;
    logic [CW-1:0]          pop_eff;
    logic [CW-1:0]          push_amt;
    logic                   push_ok;

    logic [WPORT-1:0]       we;
    logic [WPORT*INDEX-1:0] waddr;
    logic [RPORT*INDEX-1:0] raddr;

    // push acceptance uses start-of-cycle occupancy only; pops are clamped to what is held
    always_comb begin
        free_cnt = CW'(DEPTH) - count;
        wr_ext   = CW'(wr_cnt_i);
        rd_ext   = CW'(rd_cnt_i);
        push_ok  = (wr_ext <= free_cnt);
        push_amt = push_ok ? wr_ext : '0;
        pop_eff  = (rd_ext < count) ? rd_ext : count;
    end

    // pointer, occupancy and overflow-pulse registers; flush overrides push and pop
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            head     <= '0;
            tail     <= '0;
            count    <= '0;
            overflow <= 1'b0;
        end else if (flush_i) begin
            head     <= '0;
            tail     <= '0;
            count    <= '0;
            overflow <= 1'b0;
        end else begin
            head     <= head + pop_eff[INDEX-1:0];
            tail     <= tail + push_amt[INDEX-1:0];
            count    <= count + push_amt - pop_eff;
            overflow <= !push_ok;
        end
    end

    // storage port addressing: write lanes from tail, read lanes from head, both wrapping
    always_comb begin
        we    = '0;
        waddr = '0;
        raddr = '0;
        for (int k = 0; k < WPORT; k++) begin
            we[k]                  = push_ok && !flush_i && (WCW'(k) < wr_cnt_i);
            waddr[k*INDEX +: INDEX] = tail + INDEX'(k);
        end
        for (int k = 0; k < RPORT; k++) begin
            raddr[k*INDEX +: INDEX] = head + INDEX'(k);
        end
    end

    ibuff_storage #(
        .DEPTH (DEPTH),
        .WIDTH (WIDTH),
        .WPORT (WPORT),
        .RPORT (RPORT),
        .INDEX (INDEX)
    ) u_storage (
        .clk   (clk),
        .we    (we),
        .waddr (waddr),
        .wdata (wr_data_i),
        .raddr (raddr),
        .rdata (rd_data_o)
    );

    // status outputs derived from registered occupancy
    always_comb begin
        rd_valid_o = '0;
        for (int k = 0; k < RPORT; k++) begin
            rd_valid_o[k] = (CW'(k) < count);
        end
        count_o    = count;
        stall_o    = (free_cnt < CW'(WPORT));
        overflow_o = overflow;
    end

endmodule

// File: tb/tb_ibuff_queue.sv
// tb/tb_ibuff_queue.sv - scoreboard testbench for ibuff_queue
module tb_ibuff_queue;

    logic        clk = 1'b0;
    logic        reset;
    logic        flush_i;
    logic [2:0]  wr_cnt_i;
    logic [31:0] wr_data_i;
    logic [2:0]  rd_cnt_i;
    logic [31:0] rd_data_o;
    logic [3:0]  rd_valid_o;
    logic [4:0]  count_o;
    logic        stall_o;
    logic        overflow_o;

    int checks = 0;
    int errors = 0;
    logic [7:0] sb[$];

    ibuff_queue #(
        .WPORT (4),
        .RPORT (4),
        .DEPTH (16),
        .WIDTH (8)
    ) dut (
        .clk        (clk),
        .reset      (reset),
        .flush_i    (flush_i),
        .wr_cnt_i   (wr_cnt_i),
        .wr_data_i  (wr_data_i),
        .rd_cnt_i   (rd_cnt_i),
        .rd_data_o  (rd_data_o),
        .rd_valid_o (rd_valid_o),
        .count_o    (count_o),
        .stall_o    (stall_o),
        .overflow_o (overflow_o)
    );

    always #5 clk = ~clk;

    task automatic apply_reset();
        flush_i   = 1'b0;
        wr_cnt_i  = '0;
        wr_data_i = '0;
        rd_cnt_i  = '0;
        reset     = 1'b0;
        @(posedge clk);
        #3;
        reset = 1'b1;
        sb.delete();
        @(posedge clk);
        #1;
    endtask

    // one clock of stimulus; scoreboard compares visible lanes before the edge and updates after it
    task automatic sb_cycle(input int wc, input logic [31:0] data, input int rc, input bit fl);
        int n;
        int npop;
        bit acc;
        bit exp_ovf;
        logic [3:0] exp_valid;
        wr_cnt_i  = 3'(wc);
        wr_data_i = data;
        rd_cnt_i  = 3'(rc);
        flush_i   = fl;
        #1;
        n = sb.size();
        checks++;
        if (count_o !== 5'(n)) begin
            errors++;
            $display("FAIL sb_count got %0d exp %0d", count_o, n);
        end
        checks++;
        if (stall_o !== ((16 - n) < 4)) begin
            errors++;
            $display("FAIL sb_stall got %b exp %b (occupancy %0d)", stall_o, ((16 - n) < 4), n);
        end
        for (int k = 0; k < 4; k++) exp_valid[k] = (k < n);
        checks++;
        if (rd_valid_o !== exp_valid) begin
            errors++;
            $display("FAIL sb_valid got %b exp %b", rd_valid_o, exp_valid);
        end
        for (int k = 0; k < 4 && k < n; k++) begin
            checks++;
            if (rd_data_o[k*8 +: 8] !== sb[k]) begin
                errors++;
                $display("FAIL sb_lane%0d got %h exp %h", k, rd_data_o[k*8 +: 8], sb[k]);
            end
        end
        @(posedge clk);
        if (fl) begin
            sb.delete();
            exp_ovf = 1'b0;
        end else begin
            acc  = (wc <= 16 - n);
            npop = (rc < n) ? rc : n;
            for (int i = 0; i < npop; i++) void'(sb.pop_front());
            if (acc) for (int i = 0; i < wc; i++) sb.push_back(data[i*8 +: 8]);
            exp_ovf = !acc;
        end
        #1;
        checks++;
        if (overflow_o !== exp_ovf) begin
            errors++;
            $display("FAIL sb_overflow got %b exp %b", overflow_o, exp_ovf);
        end
    endtask

    task automatic test_reset();
        reset     = 1'b0;
        flush_i   = 1'b0;
        wr_cnt_i  = '0;
        wr_data_i = '0;
        rd_cnt_i  = '0;
        #12;
        checks++;
        if (count_o !== 5'd0) begin errors++; $display("FAIL reset_count got %0d exp 0", count_o); end
        checks++;
        if (rd_valid_o !== 4'b0000) begin errors++; $display("FAIL reset_valid got %b exp 0000", rd_valid_o); end
        checks++;
        if (stall_o !== 1'b0) begin errors++; $display("FAIL reset_stall got %b exp 0", stall_o); end
        checks++;
        if (overflow_o !== 1'b0) begin errors++; $display("FAIL reset_overflow got %b exp 0", overflow_o); end
        apply_reset();
    endtask

    task automatic test_push4();
        sb_cycle(4, 32'h13121110, 0, 0);
        checks++;
        if (count_o !== 5'd4) begin errors++; $display("FAIL push4_count got %0d exp 4", count_o); end
        checks++;
        if (rd_valid_o !== 4'b1111) begin errors++; $display("FAIL push4_valid got %b exp 1111", rd_valid_o); end
        checks++;
        if (rd_data_o !== 32'h13121110) begin errors++; $display("FAIL push4_lanes got %h exp 13121110", rd_data_o); end
        sb_cycle(0, 32'h0, 4, 0);
    endtask

    task automatic test_wrap();
        apply_reset();
        sb_cycle(4, 32'h03020100, 0, 0);
        sb_cycle(4, 32'h07060504, 0, 0);
        sb_cycle(4, 32'h0b0a0908, 0, 0);
        sb_cycle(2, 32'h00000d0c, 0, 0);
        sb_cycle(0, 32'h0, 4, 0);
        sb_cycle(0, 32'h0, 4, 0);
        sb_cycle(0, 32'h0, 4, 0);
        sb_cycle(0, 32'h0, 2, 0);
        checks++;
        if (dut.head !== 4'd14 || dut.tail !== 4'd14 || count_o !== 5'd0) begin
            errors++;
            $display("FAIL wrap_setup got head %0d tail %0d count %0d exp 14 14 0", dut.head, dut.tail, count_o);
        end
        sb_cycle(4, 32'hA3A2A1A0, 0, 0);
        checks++;
        if (dut.tail !== 4'd2) begin errors++; $display("FAIL wrap_tail got %0d exp 2", dut.tail); end
        checks++;
        if (rd_data_o !== 32'hA3A2A1A0) begin errors++; $display("FAIL wrap_lanes got %h exp a3a2a1a0", rd_data_o); end
        checks++;
        if (dut.u_storage.mem[15] !== 8'hA1 || dut.u_storage.mem[0] !== 8'hA2) begin
            errors++;
            $display("FAIL wrap_storage got %h %h exp a1 a2", dut.u_storage.mem[15], dut.u_storage.mem[0]);
        end
        sb_cycle(0, 32'h0, 4, 0);
    endtask

    task automatic test_overflow();
        sb_cycle(0, 32'h0, 0, 1);
        sb_cycle(4, 32'h33323130, 0, 0);
        sb_cycle(4, 32'h37363534, 0, 0);
        sb_cycle(4, 32'h3b3a3938, 0, 0);
        sb_cycle(1, 32'h0000003c, 0, 0);
        checks++;
        if (stall_o !== 1'b1) begin errors++; $display("FAIL ovf_stall_before got %b exp 1", stall_o); end
        sb_cycle(4, 32'hEEEEEEEE, 0, 0);
        checks++;
        if (count_o !== 5'd13 || overflow_o !== 1'b1 || stall_o !== 1'b1) begin
            errors++;
            $display("FAIL ovf_reject got count %0d ovf %b stall %b exp 13 1 1", count_o, overflow_o, stall_o);
        end
        sb_cycle(0, 32'h0, 0, 0);
        checks++;
        if (overflow_o !== 1'b0 || stall_o !== 1'b1) begin
            errors++;
            $display("FAIL ovf_pulse got ovf %b stall %b exp 0 1", overflow_o, stall_o);
        end
    endtask

    task automatic test_simultaneous();
        sb_cycle(0, 32'h0, 0, 1);
        sb_cycle(4, 32'h23222120, 0, 0);
        sb_cycle(1, 32'h00000024, 0, 0);
        sb_cycle(3, 32'h00272625, 2, 0);
        checks++;
        if (count_o !== 5'd6 || rd_data_o[7:0] !== 8'h22) begin
            errors++;
            $display("FAIL simul_push_pop got count %0d head %h exp 6 22", count_o, rd_data_o[7:0]);
        end
        sb_cycle(0, 32'h0, 4, 0);
        sb_cycle(0, 32'h0, 4, 0);
        checks++;
        if (count_o !== 5'd0 || rd_valid_o !== 4'b0000) begin
            errors++;
            $display("FAIL simul_overpop got count %0d valid %b exp 0 0000", count_o, rd_valid_o);
        end
    endtask

    task automatic test_flush();
        sb_cycle(4, 32'h43424140, 0, 0);
        sb_cycle(4, 32'h47464544, 0, 0);
        sb_cycle(1, 32'h00000048, 0, 0);
        sb_cycle(4, 32'h5b5a5958, 2, 1);
        checks++;
        if (count_o !== 5'd0 || rd_valid_o !== 4'b0000 || stall_o !== 1'b0 || overflow_o !== 1'b0) begin
            errors++;
            $display("FAIL flush got count %0d valid %b stall %b ovf %b exp 0 0000 0 0",
                     count_o, rd_valid_o, stall_o, overflow_o);
        end
    endtask

    task automatic test_async_reset();
        realtime t0;
        sb_cycle(4, 32'h63626160, 0, 0);
        sb_cycle(3, 32'h00666564, 0, 0);
        wr_cnt_i = '0;
        rd_cnt_i = '0;
        #3;
        t0    = $realtime;
        reset = 1'b0;
        #1;
        checks++;
        if (count_o !== 5'd0 || rd_valid_o !== 4'b0000 || ($realtime - t0) > 4.0) begin
            errors++;
            $display("FAIL async_reset got count %0d valid %b exp 0 0000", count_o, rd_valid_o);
        end
        sb.delete();
        #2;
        reset = 1'b1;
        @(posedge clk);
        #1;
    endtask

    task automatic test_random();
        for (int i = 0; i < 300; i++) begin
            sb_cycle($urandom_range(0, 4), $urandom, $urandom_range(0, 4), ($urandom_range(0, 31) == 0));
        end
    endtask

    initial begin
        test_reset();
        test_push4();
        test_wrap();
        test_overflow();
        test_simultaneous();
        test_flush();
        test_async_reset();
        test_random();
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule

// File: doc/ibuff_queue.md
IBUFF_QUEUE -- requirements
Module: ibuff_queue

Interface
REQ-001 The block SHALL have exactly one clock, clk, and one asynchronous, active-low reset, reset.
REQ-002 Parameter WPORT, default 2*`FETCH_WIDTH: maximum entries pushed per cycle.
REQ-003 Parameter RPORT, default `DISPATCH_WIDTH: maximum entries presented and popped per cycle.
REQ-004 Parameter DEPTH, default 16: number of entries; power of two, at least max(WPORT,RPORT).
REQ-005 Parameter WIDTH, default 8: entry width in bits.
REQ-006 Local constants: INDEX = $clog2(DEPTH); WCW = $clog2(WPORT+1); RCW = $clog2(RPORT+1).
REQ-007 clk  input  1  rising-edge clock.
REQ-008 reset  input  1  asynchronous active-low reset.
REQ-009 flush_i  input  1  discard all contents.
REQ-010 wr_cnt_i  input  WCW  number of lanes to push; lanes 0..wr_cnt_i-1 are used, lane 0 oldest.
REQ-011 wr_data_i  input  WPORT*WIDTH  packed push data; lane k at bits [k*WIDTH +: WIDTH].
REQ-012 rd_cnt_i  input  RCW  number of entries to pop this cycle.
REQ-013 rd_data_o  output  RPORT*WIDTH  packed oldest entries; lane 0 is the head.
REQ-014 rd_valid_o  output  RPORT  lane k holds a live entry.
REQ-015 count_o  output  INDEX+1  current occupancy.
REQ-016 stall_o  output  1  free entries < WPORT.
REQ-017 overflow_o  output  1  one-cycle pulse for a rejected push.

Function
REQ-018 State SHALL be head and tail pointers (INDEX bits, wrap modulo DEPTH), count (INDEX+1 bits) and a DEPTH x WIDTH storage array.
REQ-019 A push SHALL be accepted when wr_cnt_i <= DEPTH - count, using count at cycle start; same-cycle pops give no credit.
REQ-020 An accepted push SHALL write lane k to entry (tail+k) mod DEPTH for k < wr_cnt_i and advance tail by wr_cnt_i.
REQ-021 A rejected push SHALL change no storage, tail or count, and SHALL set overflow_o high for exactly the next cycle.
REQ-022 rd_data_o lane k SHALL combinationally show entry (head+k) mod DEPTH; rd_valid_o[k] SHALL equal (k < count).
REQ-023 The effective pop SHALL be min(rd_cnt_i, count); head SHALL advance by that amount; over-popping is clamped silently.
REQ-024 Next count SHALL equal count + accepted push - effective pop, in the same cycle.
REQ-025 No write-to-read bypass: an entry pushed at edge N SHALL first appear on rd_data_o after edge N.
REQ-026 stall_o SHALL equal (DEPTH - count) < WPORT, derived combinationally from registered count.
REQ-027 Flush SHALL take priority: on the edge with flush_i high, head, tail and count SHALL become 0, overflow_o SHALL become 0, and push and pop SHALL be ignored.
REQ-028 When count == DEPTH, all rd_valid_o bits SHALL be 1 and every nonzero push SHALL be rejected.
REQ-029 rd_data_o lanes with rd_valid_o low SHALL be don't-care.

Reset
REQ-030 While reset is low, head, tail, count and overflow_o SHALL be 0, asynchronously, without a clock edge.
REQ-031 Output values while reset is low SHALL be: rd_valid_o = 0, count_o = 0, stall_o = 0, overflow_o = 0.
REQ-032 Storage SHALL NOT be reset.

Structure
REQ-033 Package ibuff_pkg SHALL hold the WPORT/RPORT defaults derived from the FETCH/DISPATCH width macros and an ibuff_entry_t typedef of WIDTH bits.
REQ-034 Storage SHALL be one sub-module, ibuff_storage, with WPORT write ports, RPORT read ports, combinational read, no reset.
REQ-035 Elaboration SHALL fail if DEPTH is not a power of two or is below max(WPORT,RPORT).

Verification (DEPTH=16, WPORT=4, RPORT=4, WIDTH=8)
REQ-036 Reset, then push 4 entries 0x10..0x13 -> next cycle: count_o=4, rd_valid_o=4'b1111, lanes=0x10,0x11,0x12,0x13.
REQ-037 Wrap: head=tail=14 and empty; push 4 entries 0xA0..0xA3 -> entries land in 14,15,0,1, lanes read 0xA0..0xA3, tail=2.
REQ-038 Overflow: count=13, push 4 -> rejected, count stays 13, overflow_o=1 for exactly one cycle, stall_o=1 throughout.
REQ-039 Simultaneous: count=5, push 3 and pop 2 -> count=6, new head is the old lane 2; count=2 with rd_cnt_i=4 -> count=0, rd_valid_o=0.
REQ-040 Flush with push 4 and pop 2 asserted at count=9 -> count=0, rd_valid_o=0, stall_o=0, overflow_o=0 next cycle.
REQ-041 Assert reset between clock edges at count=7 -> count_o=0 and rd_valid_o=0 immediately, with no clock edge.
